ex_stage: RTL and testbench

- Execute stage of the 5-stage MIPS32 integer pipeline.
- Holds the ID/EX pipeline register that captures decode outputs, performs logic and shift operations on the registered operands, and holds the EX/MEM pipeline register.
- Exposes the current execute result combinationally, so decode can forward from EX.
- Exposes the registered EX/MEM result, so decode can forward from MEM and the MEM stage can consume it.

---
 rtl/ex_stage_if.sv | 33 +++
 rtl/ex_stage.sv | 130 +++++++++++++
 tb/tb_ex_stage.sv | 261 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/ex_stage_if.sv
// Decode <-> execute bundle: decode-stage instruction fields in, EX and MEM forwarding results out.
interface ex_stage_if #(
    parameter int DW = 32,
    parameter int RW = 5
);
    logic [7:0]    id_aluop_i;
    logic [2:0]    id_alusel_i;
    logic [DW-1:0] id_reg1_i;
    logic [DW-1:0] id_reg2_i;
    logic [RW-1:0] id_wd_i;
    logic          id_wreg_i;

    logic [DW-1:0] ex_wdata_o;
    logic [RW-1:0] ex_wd_o;
    logic          ex_wreg_o;

    logic [DW-1:0] mem_wdata_o;
    logic [RW-1:0] mem_wd_o;
    logic          mem_wreg_o;

    // Decode side drives instruction fields and consumes forwarded results.
    modport master (
        output id_aluop_i, id_alusel_i, id_reg1_i, id_reg2_i, id_wd_i, id_wreg_i,
        input  ex_wdata_o, ex_wd_o, ex_wreg_o,
        input  mem_wdata_o, mem_wd_o, mem_wreg_o
    );

    modport slave (
        input  id_aluop_i, id_alusel_i, id_reg1_i, id_reg2_i, id_wd_i, id_wreg_i,
        output ex_wdata_o, ex_wd_o, ex_wreg_o,
        output mem_wdata_o, mem_wd_o, mem_wreg_o
    );
endinterface

// File: rtl/ex_stage.sv
// MIPS32 execute stage: ID/EX register, logic/shift unit, EX/MEM register.
// Latency: id_* -> ex_* one edge, id_* -> mem_* two edges; ex_wdata is combinational from ID/EX.
// Backpressure: stall vector holds or bubbles each register; flush and rst clear both synchronously.
module ex_stage #(
    parameter int DW = 32,
    parameter int RW = 5
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       stall_id,
    input  logic       stall_ex,
    input  logic       stall_mem,
    input  logic       flush,
    ex_stage_if.slave  bus
);

    localparam logic [2:0] SEL_NOP   = 3'b000;
    localparam logic [2:0] SEL_LOGIC = 3'b001;
    localparam logic [2:0] SEL_SHIFT = 3'b010;

    localparam logic [7:0] OP_AND  = 8'b0010_0100;
    localparam logic [7:0] OP_OR   = 8'b0010_0101;
    localparam logic [7:0] OP_XOR  = 8'b0010_0110;
    localparam logic [7:0] OP_NOR  = 8'b0010_0111;
    localparam logic [7:0] OP_ANDI = 8'b0101_1001;
    localparam logic [7:0] OP_SLL  = 8'b0111_1100;
    localparam logic [7:0] OP_SRL  = 8'b0000_0010;
    localparam logic [7:0] OP_SRA  = 8'b0000_0011;
    localparam logic [7:0] OP_SRLV = 8'b0000_0110;
    localparam logic [7:0] OP_SRAV = 8'b0000_0111;

    typedef struct packed {
        logic [7:0]    aluop;
        logic [2:0]    alusel;
        logic [DW-1:0] reg1;
        logic [DW-1:0] reg2;
        logic [RW-1:0] wd;
        logic          wreg;
    } idex_t;

    typedef struct packed {
        logic [DW-1:0] wdata;
        logic [RW-1:0] wd;
        logic          wreg;
    } exmem_t;

    idex_t   idex_q;
    idex_t   id_in;
    exmem_t  exmem_q;
    exmem_t  ex_out;

    logic [DW-1:0] logic_res;
    logic [DW-1:0] shift_res;
    logic [DW-1:0] ex_wdata;
    logic [4:0]    sa;

    assign id_in.aluop  = bus.id_aluop_i;
    assign id_in.alusel = bus.id_alusel_i;
    assign id_in.reg1   = bus.id_reg1_i;
    assign id_in.reg2   = bus.id_reg2_i;
    assign id_in.wd     = bus.id_wd_i;
    assign id_in.wreg   = bus.id_wreg_i;

    // Bubble when decode stalls but execute advances; hold only when both stall.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            idex_q <= '0;
        end else if (stall_id && !stall_ex) begin
            idex_q <= '0;
        end else if (!stall_id) begin
            idex_q <= id_in;
        end
    end

    always_comb begin
        logic_res = '0;
        case (idex_q.aluop)
            OP_AND, OP_ANDI: logic_res = idex_q.reg1 & idex_q.reg2;
            OP_OR:           logic_res = idex_q.reg1 | idex_q.reg2;
            OP_XOR:          logic_res = idex_q.reg1 ^ idex_q.reg2;
            OP_NOR:          logic_res = ~(idex_q.reg1 | idex_q.reg2);
            default:         logic_res = '0;
        endcase
    end

    // Shift amount always comes from reg1: decode places shamt or rs there.
    assign sa = idex_q.reg1[4:0];

    always_comb begin
        shift_res = '0;
        case (idex_q.aluop)
            OP_SLL:          shift_res = idex_q.reg2 << sa;
            OP_SRL, OP_SRLV: shift_res = idex_q.reg2 >> sa;
            OP_SRA, OP_SRAV: shift_res = $unsigned($signed(idex_q.reg2) >>> sa);
            default:         shift_res = '0;
        endcase
    end

    always_comb begin
        ex_wdata = '0;
        case (idex_q.alusel)
            SEL_LOGIC: ex_wdata = logic_res;
            SEL_SHIFT: ex_wdata = shift_res;
            SEL_NOP:   ex_wdata = '0;
            default:   ex_wdata = '0;
        endcase
    end

    assign ex_out.wdata = ex_wdata;
    assign ex_out.wd    = idex_q.wd;
    assign ex_out.wreg  = idex_q.wreg;

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            exmem_q <= '0;
        end else if (stall_ex && !stall_mem) begin
            exmem_q <= '0;
        end else if (!stall_ex) begin
            exmem_q <= ex_out;
        end
    end

    assign bus.ex_wdata_o  = ex_out.wdata;
    assign bus.ex_wd_o     = ex_out.wd;
    assign bus.ex_wreg_o   = ex_out.wreg;
    assign bus.mem_wdata_o = exmem_q.wdata;
    assign bus.mem_wd_o    = exmem_q.wd;
    assign bus.mem_wreg_o  = exmem_q.wreg;

endmodule

// File: tb/tb_ex_stage.sv
// Bench for ex_stage: directed vector table, multi-cycle stall/flush sequences, randomized run against a reference model.
module tb_ex_stage;

    localparam logic [2:0] S_NOP = 3'b000, S_LOG = 3'b001, S_SHF = 3'b010;
    localparam logic [7:0] O_AND = 8'h24, O_OR = 8'h25, O_XOR = 8'h26, O_NOR = 8'h27, O_ANDI = 8'h59;
    localparam logic [7:0] O_SLL = 8'h7C, O_SRL = 8'h02, O_SRA = 8'h03, O_SRLV = 8'h06, O_SRAV = 8'h07;

    logic clk = 1'b0;
    logic rst, stall_id, stall_ex, stall_mem, flush;
    int   n_cmp = 0;
    int   n_err = 0;

    ex_stage_if #(.DW(32), .RW(5)) bus ();

    ex_stage #(.DW(32), .RW(5)) u_dut (
        .clk       (clk),
        .rst       (rst),
        .stall_id  (stall_id),
        .stall_ex  (stall_ex),
        .stall_mem (stall_mem),
        .flush     (flush),
        .bus       (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0]  aluop;
        logic [2:0]  alusel;
        logic [31:0] r1;
        logic [31:0] r2;
        logic [31:0] exp;
    } vec_t;

    typedef struct packed {
        logic [7:0]  aluop;
        logic [2:0]  alusel;
        logic [31:0] r1;
        logic [31:0] r2;
        logic [4:0]  wd;
        logic        wreg;
    } instr_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic [7:0] op, input logic [2:0] sel, input logic [31:0] r1,
                         input logic [31:0] r2, input logic [4:0] wd, input logic wreg);
        bus.id_aluop_i  = op;
        bus.id_alusel_i = sel;
        bus.id_reg1_i   = r1;
        bus.id_reg2_i   = r2;
        bus.id_wd_i     = wd;
        bus.id_wreg_i   = wreg;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference result from the instruction set rules, using arithmetic rather than shift operators.
    function automatic logic [31:0] ref_result(input instr_t i);
        logic [31:0] p2;
        logic [31:0] lsr;
        p2  = 32'd1 << i.r1[4:0];
        lsr = i.r2 / p2;
        if (i.alusel == S_LOG) begin
            if (i.aluop == O_AND || i.aluop == O_ANDI) return i.r1 & i.r2;
            if (i.aluop == O_OR)  return i.r1 | i.r2;
            if (i.aluop == O_XOR) return i.r1 ^ i.r2;
            if (i.aluop == O_NOR) return ~(i.r1 | i.r2);
            return 32'd0;
        end
        if (i.alusel == S_SHF) begin
            if (i.aluop == O_SLL) return i.r2 * p2;
            if (i.aluop == O_SRL || i.aluop == O_SRLV) return lsr;
            if (i.aluop == O_SRA || i.aluop == O_SRAV)
                return i.r2[31] ? (lsr | ~(32'hFFFF_FFFF / p2)) : lsr;
            return 32'd0;
        end
        return 32'd0;
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t   vecs[$];
        instr_t m_id, nx_id, cur;
        logic [31:0] m_mw, nx_mw;
        logic [4:0]  m_mwd, nx_mwd;
        logic        m_mwr, nx_mwr;
        logic [7:0]  ops[10];

        rst = 1'b1; stall_id = 1'b0; stall_ex = 1'b0; stall_mem = 1'b0; flush = 1'b0;
        drive(O_OR, S_LOG, 32'h0000_F0F0, 32'h00FF_00FF, 5'd3, 1'b1);

        // Reset and OR
        for (int c = 0; c < 2; c++) begin
            step();
            chk("rst_ex_wdata", bus.ex_wdata_o, 32'd0);
            chk("rst_ex_wd", {27'd0, bus.ex_wd_o}, 32'd0);
            chk("rst_ex_wreg", {31'd0, bus.ex_wreg_o}, 32'd0);
            chk("rst_mem_wdata", bus.mem_wdata_o, 32'd0);
            chk("rst_mem_wd", {27'd0, bus.mem_wd_o}, 32'd0);
            chk("rst_mem_wreg", {31'd0, bus.mem_wreg_o}, 32'd0);
        end
        rst = 1'b0;
        step();
        chk("or_ex_wdata", bus.ex_wdata_o, 32'h00FF_F0FF);
        chk("or_ex_wd", {27'd0, bus.ex_wd_o}, 32'd3);
        chk("or_ex_wreg", {31'd0, bus.ex_wreg_o}, 32'd1);
        drive(8'h00, S_NOP, 32'd0, 32'd0, 5'd0, 1'b0);
        step();
        chk("or_mem_wdata", bus.mem_wdata_o, 32'h00FF_F0FF);
        chk("or_mem_wd", {27'd0, bus.mem_wd_o}, 32'd3);
        chk("or_mem_wreg", {31'd0, bus.mem_wreg_o}, 32'd1);

        // Logic and shift vector table
        vecs.push_back('{O_AND,  S_LOG, 32'hFFFF_0000, 32'h0F0F_0F0F, 32'h0F0F_0000});
        vecs.push_back('{O_XOR,  S_LOG, 32'hFFFF_0000, 32'h0F0F_0F0F, 32'hF0F0_0F0F});
        vecs.push_back('{O_NOR,  S_LOG, 32'hFFFF_0000, 32'h0F0F_0F0F, 32'h0000_F0F0});
        vecs.push_back('{O_ANDI, S_LOG, 32'hFFFF_0000, 32'h0F0F_0F0F, 32'h0F0F_0000});
        vecs.push_back('{8'h55,  S_LOG, 32'hFFFF_0000, 32'h0F0F_0F0F, 32'h0000_0000});
        vecs.push_back('{O_SLL,  S_SHF, 32'h0000_0004, 32'h8000_0010, 32'h0000_0100});
        vecs.push_back('{O_SRL,  S_SHF, 32'h0000_0004, 32'h8000_0010, 32'h0800_0001});
        vecs.push_back('{O_SRA,  S_SHF, 32'h0000_0004, 32'h8000_0010, 32'hF800_0001});
        vecs.push_back('{O_SRAV, S_SHF, 32'hFFFF_FFE4, 32'h8000_0010, 32'hF800_0001});
        vecs.push_back('{O_SRLV, S_SHF, 32'h0000_0000, 32'h8000_0010, 32'h8000_0010});
        vecs.push_back('{O_SRA,  S_SHF, 32'h0000_0000, 32'h8000_0010, 32'h8000_0010});
        vecs.push_back('{O_SRA,  S_SHF, 32'h0000_001F, 32'h8000_0010, 32'hFFFF_FFFF});
        vecs.push_back('{O_SRL,  S_SHF, 32'h0000_001F, 32'h8000_0010, 32'h0000_0001});
        vecs.push_back('{O_AND,  S_SHF, 32'h0000_0004, 32'h8000_0010, 32'h0000_0000});
        vecs.push_back('{O_OR,   S_NOP, 32'hFFFF_0000, 32'h0F0F_0F0F, 32'h0000_0000});
        vecs.push_back('{O_OR,   3'b100, 32'hFFFF_0000, 32'h0F0F_0F0F, 32'h0000_0000});
        foreach (vecs[k]) begin
            drive(vecs[k].aluop, vecs[k].alusel, vecs[k].r1, vecs[k].r2, 5'(k + 1), 1'b1);
            step();
            chk($sformatf("vec%0d_ex_wdata", k), bus.ex_wdata_o, vecs[k].exp);
        end

        // Stall handling: A, then B stalled in decode, then C, then full stall with D waiting
        drive(O_OR, S_LOG, 32'h0000_000A, 32'h0000_0100, 5'd10, 1'b1);
        step();
        drive(O_OR, S_LOG, 32'h0000_000B, 32'h0000_0200, 5'd11, 1'b1);
        stall_id = 1'b1;
        step();
        chk("stl_bubble_ex_wdata", bus.ex_wdata_o, 32'd0);
        chk("stl_bubble_ex_wreg", {31'd0, bus.ex_wreg_o}, 32'd0);
        chk("stl_a_mem_wdata", bus.mem_wdata_o, 32'h0000_010A);
        stall_id = 1'b0;
        step();
        chk("stl_b_ex_wdata", bus.ex_wdata_o, 32'h0000_020B);
        chk("stl_b_ex_wd", {27'd0, bus.ex_wd_o}, 32'd11);
        drive(O_OR, S_LOG, 32'h0000_000C, 32'h0000_0300, 5'd12, 1'b1);
        step();
        drive(O_OR, S_LOG, 32'h0000_000D, 32'h0000_0400, 5'd13, 1'b1);
        stall_id = 1'b1; stall_ex = 1'b1; stall_mem = 1'b1;
        for (int c = 0; c < 3; c++) begin
            step();
            chk("hold_ex_wdata", bus.ex_wdata_o, 32'h0000_030C);
            chk("hold_mem_wdata", bus.mem_wdata_o, 32'h0000_020B);
            chk("hold_mem_wd", {27'd0, bus.mem_wd_o}, 32'd11);
        end
        stall_mem = 1'b0;
        step();
        chk("memb_ex_wdata", bus.ex_wdata_o, 32'h0000_030C);
        chk("memb_mem_wdata", bus.mem_wdata_o, 32'd0);
        chk("memb_mem_wreg", {31'd0, bus.mem_wreg_o}, 32'd0);
        stall_id = 1'b0; stall_ex = 1'b0;
        step();
        chk("rel_ex_wdata", bus.ex_wdata_o, 32'h0000_040D);
        chk("rel_mem_wdata", bus.mem_wdata_o, 32'h0000_030C);

        // Flush while a valid OR occupies both registers under stall
        drive(O_OR, S_LOG, 32'h1234_0000, 32'h0000_5678, 5'd7, 1'b1);
        step();
        step();
        chk("pre_flush_mem_wdata", bus.mem_wdata_o, 32'h1234_5678);
        stall_id = 1'b1; stall_ex = 1'b1; stall_mem = 1'b1; flush = 1'b1;
        step();
        chk("flush_ex_wdata", bus.ex_wdata_o, 32'd0);
        chk("flush_ex_wd", {27'd0, bus.ex_wd_o}, 32'd0);
        chk("flush_ex_wreg", {31'd0, bus.ex_wreg_o}, 32'd0);
        chk("flush_mem_wdata", bus.mem_wdata_o, 32'd0);
        chk("flush_mem_wd", {27'd0, bus.mem_wd_o}, 32'd0);
        chk("flush_mem_wreg", {31'd0, bus.mem_wreg_o}, 32'd0);
        flush = 1'b0; stall_id = 1'b0; stall_ex = 1'b0; stall_mem = 1'b0;

        // Back-to-back issue
        drive(O_XOR, S_LOG, 32'h0000_00FF, 32'h0000_0F0F, 5'd1, 1'b1);
        step();
        chk("b2b_i1_ex", bus.ex_wdata_o, 32'h0000_0FF0);
        drive(O_SLL, S_SHF, 32'h0000_0008, 32'h0000_00AB, 5'd2, 1'b1);
        step();
        chk("b2b_i2_ex", bus.ex_wdata_o, 32'h0000_AB00);
        chk("b2b_i1_mem", bus.mem_wdata_o, 32'h0000_0FF0);
        chk("b2b_i1_mem_wd", {27'd0, bus.mem_wd_o}, 32'd1);
        drive(O_NOR, S_LOG, 32'h0000_0000, 32'hFFFF_FF00, 5'd4, 1'b1);
        step();
        chk("b2b_i3_ex", bus.ex_wdata_o, 32'h0000_00FF);
        chk("b2b_i2_mem", bus.mem_wdata_o, 32'h0000_AB00);
        drive(8'h00, S_NOP, 32'd0, 32'd0, 5'd0, 1'b0);
        step();
        chk("b2b_i3_mem", bus.mem_wdata_o, 32'h0000_00FF);
        chk("b2b_i3_mem_wd", {27'd0, bus.mem_wd_o}, 32'd4);

        // Randomized run against the reference model, starting from a reset
        ops = '{O_AND, O_OR, O_XOR, O_NOR, O_ANDI, O_SLL, O_SRL, O_SRA, O_SRLV, O_SRAV};
        rst = 1'b1;
        step();
        rst = 1'b0;
        m_id = '0; m_mw = '0; m_mwd = '0; m_mwr = 1'b0;
        for (int c = 0; c < 600; c++) begin
            cur.aluop  = ($urandom_range(0, 9) == 0) ? 8'($urandom) : ops[$urandom_range(0, 9)];
            cur.alusel = ($urandom_range(0, 7) == 0) ? 3'($urandom) : 3'($urandom_range(1, 2));
            cur.r1     = $urandom;
            cur.r2     = $urandom;
            cur.wd     = 5'($urandom);
            cur.wreg   = 1'($urandom);
            drive(cur.aluop, cur.alusel, cur.r1, cur.r2, cur.wd, cur.wreg);
            stall_id  = ($urandom_range(0, 3) == 0);
            stall_ex  = ($urandom_range(0, 4) == 0);
            stall_mem = ($urandom_range(0, 4) == 0);
            flush     = ($urandom_range(0, 29) == 0);
            rst       = ($urandom_range(0, 99) == 0);

            nx_id = m_id;
            if (rst || flush || (stall_id && !stall_ex)) nx_id = '0;
            else if (!stall_id) nx_id = cur;
            nx_mw = m_mw; nx_mwd = m_mwd; nx_mwr = m_mwr;
            if (rst || flush || (stall_ex && !stall_mem)) begin
                nx_mw = '0; nx_mwd = '0; nx_mwr = 1'b0;
            end else if (!stall_ex) begin
                nx_mw = ref_result(m_id); nx_mwd = m_id.wd; nx_mwr = m_id.wreg;
            end

            step();
            m_id = nx_id; m_mw = nx_mw; m_mwd = nx_mwd; m_mwr = nx_mwr;
            chk("rnd_ex_wdata", bus.ex_wdata_o, ref_result(m_id));
            chk("rnd_ex_wd", {27'd0, bus.ex_wd_o}, {27'd0, m_id.wd});
            chk("rnd_ex_wreg", {31'd0, bus.ex_wreg_o}, {31'd0, m_id.wreg});
            chk("rnd_mem_wdata", bus.mem_wdata_o, m_mw);
            chk("rnd_mem_wd", {27'd0, bus.mem_wd_o}, {27'd0, m_mwd});
            chk("rnd_mem_wreg", {31'd0, bus.mem_wreg_o}, {31'd0, m_mwr});
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
